// File: rtl/sdc_host_if.sv
// Host-side front end of the SDRAM controller user port: command handshake,
// write-data FIFO, request sequencing to the controller and read-data return.
module sdc_host_if #(
    parameter int ADR_W  = 23,
    parameter int DATA_W = 32,
    parameter int WF_AW  = 5
) (
    input  logic              mclk,
    input  logic              s_resetn,
    input  logic              hst_cmd_valid,
    output logic              hst_cmd_ready,
    input  logic [ADR_W-1:0]  hst_cmd_adr,
    input  logic [1:0]        hst_cmd_len,
    input  logic              hst_cmd_wr_n,
    input  logic [3:0]        hst_cmd_be_n,
    input  logic              hst_wd_valid,
    output logic              hst_wd_ready,
    input  logic [DATA_W-1:0] hst_wd,
    output logic              hst_rd_valid,
    output logic [DATA_W-1:0] hst_rd,
    output logic              hst_rd_last,
    input  logic              sdc_init_done,
    output logic              sdc_req,
    output logic [ADR_W-1:0]  sdc_req_adr,
    output logic [1:0]        sdc_req_len,
    output logic              sdc_req_wr_n,
    input  logic              sdc_req_ack,
    input  logic              sdc_wr_next,
    output logic [DATA_W-1:0] sdc_wr_data,
    output logic [3:0]        sdc_wr_en_n,
    input  logic [DATA_W-1:0] sdc_rd_data,
    input  logic              sdc_rd_valid,
    output logic              busy,
    output logic              err
);
    localparam int DEPTH = 2 ** WF_AW;
    localparam int CNT_W = WF_AW + 1;

    typedef enum logic [2:0] {IDLE, WDAT, REQ, WR, RD} state_t;
    state_t state, state_next;

    logic [DATA_W-1:0] fifo_mem [DEPTH];
    logic [WF_AW-1:0]  wr_ptr, rd_ptr;
    logic [CNT_W-1:0]  fifo_cnt;
    logic [5:0]        words, beat;
    logic              cmd_accept, push, pop, rd_take, beat_last, fifo_empty;

    assign fifo_empty    = (fifo_cnt == '0);
    assign hst_cmd_ready = (state == IDLE) && sdc_init_done;
    assign hst_wd_ready  = (fifo_cnt != CNT_W'(DEPTH));
    assign cmd_accept    = hst_cmd_valid & hst_cmd_ready;
    assign push          = hst_wd_valid & hst_wd_ready;
    assign beat_last     = (beat == words - 6'd1);
    assign sdc_wr_data   = fifo_mem[rd_ptr];
    assign busy          = (state != IDLE);

    // A data beat arriving together with the ack already belongs to the burst.
    always_comb begin
        state_next = state;
        pop        = 1'b0;
        rd_take    = 1'b0;
        case (state)
            IDLE: if (cmd_accept) state_next = hst_cmd_wr_n ? REQ : WDAT;
            WDAT: if (32'(fifo_cnt) >= 32'(words)) state_next = REQ;
            REQ: begin
                if (sdc_req_ack) begin
                    state_next = sdc_req_wr_n ? RD : WR;
                    pop        = ~sdc_req_wr_n & sdc_wr_next & ~fifo_empty;
                    rd_take    = sdc_req_wr_n & sdc_rd_valid;
                end
            end
            WR: begin
                pop = sdc_wr_next & ~fifo_empty;
                if (pop && beat_last) state_next = IDLE;
            end
            RD: begin
                rd_take = sdc_rd_valid;
                if (rd_take && beat_last) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge mclk or negedge s_resetn) begin
        if (!s_resetn) begin
            state        <= IDLE;
            sdc_req      <= 1'b0;
            sdc_req_adr  <= '0;
            sdc_req_len  <= 2'd0;
            sdc_req_wr_n <= 1'b1;
            sdc_wr_en_n  <= 4'hF;
            words        <= 6'd0;
            beat         <= 6'd0;
            hst_rd_valid <= 1'b0;
            hst_rd       <= '0;
            hst_rd_last  <= 1'b0;
            err          <= 1'b0;
        end else begin
            state        <= state_next;
            sdc_req      <= (state_next == REQ);
            hst_rd_valid <= rd_take;
            hst_rd_last  <= rd_take & beat_last;
            if (rd_take) hst_rd <= sdc_rd_data;
            if (cmd_accept) begin
                sdc_req_adr  <= hst_cmd_adr;
                sdc_req_len  <= hst_cmd_len;
                sdc_req_wr_n <= hst_cmd_wr_n;
                sdc_wr_en_n  <= hst_cmd_be_n;
                words        <= 6'd4 << hst_cmd_len;
                beat         <= 6'd0;
            end else if (pop || rd_take) begin
                beat <= beat + 6'd1;
            end
            err <= err | (sdc_wr_next & ~pop) | (sdc_rd_valid & ~rd_take)
                       | (sdc_req_ack & (state != REQ));
        end
    end

    always_ff @(posedge mclk or negedge s_resetn) begin
        if (!s_resetn) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            fifo_cnt <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   fifo_cnt <= fifo_cnt + 1'b1;
                2'b01:   fifo_cnt <= fifo_cnt - 1'b1;
                default: fifo_cnt <= fifo_cnt;
            endcase
        end
    end

    always_ff @(posedge mclk) begin
        if (push) fifo_mem[wr_ptr] <= hst_wd;
    end
endmodule

// File: tb/tb_sdc_host_if.sv
// Directed self-checking bench for sdc_host_if: write/read bursts, FIFO limits,
// error flag and mid-burst reset.
module tb_sdc_host_if;
    localparam int ADR_W = 23, DATA_W = 32, WF_AW = 5;

    logic              mclk = 1'b0;
    logic              s_resetn;
    logic              hst_cmd_valid, hst_cmd_ready;
    logic [ADR_W-1:0]  hst_cmd_adr;
    logic [1:0]        hst_cmd_len;
    logic              hst_cmd_wr_n;
    logic [3:0]        hst_cmd_be_n;
    logic              hst_wd_valid, hst_wd_ready;
    logic [DATA_W-1:0] hst_wd;
    logic              hst_rd_valid, hst_rd_last;
    logic [DATA_W-1:0] hst_rd;
    logic              sdc_init_done, sdc_req, sdc_req_wr_n, sdc_req_ack, sdc_wr_next;
    logic [ADR_W-1:0]  sdc_req_adr;
    logic [1:0]        sdc_req_len;
    logic [DATA_W-1:0] sdc_wr_data, sdc_rd_data;
    logic [3:0]        sdc_wr_en_n;
    logic              sdc_rd_valid, busy, err;

    int checks = 0;
    int errors = 0;

    sdc_host_if #(.ADR_W(ADR_W), .DATA_W(DATA_W), .WF_AW(WF_AW)) dut (
        .mclk(mclk), .s_resetn(s_resetn),
        .hst_cmd_valid(hst_cmd_valid), .hst_cmd_ready(hst_cmd_ready),
        .hst_cmd_adr(hst_cmd_adr), .hst_cmd_len(hst_cmd_len),
        .hst_cmd_wr_n(hst_cmd_wr_n), .hst_cmd_be_n(hst_cmd_be_n),
        .hst_wd_valid(hst_wd_valid), .hst_wd_ready(hst_wd_ready), .hst_wd(hst_wd),
        .hst_rd_valid(hst_rd_valid), .hst_rd(hst_rd), .hst_rd_last(hst_rd_last),
        .sdc_init_done(sdc_init_done), .sdc_req(sdc_req), .sdc_req_adr(sdc_req_adr),
        .sdc_req_len(sdc_req_len), .sdc_req_wr_n(sdc_req_wr_n), .sdc_req_ack(sdc_req_ack),
        .sdc_wr_next(sdc_wr_next), .sdc_wr_data(sdc_wr_data), .sdc_wr_en_n(sdc_wr_en_n),
        .sdc_rd_data(sdc_rd_data), .sdc_rd_valid(sdc_rd_valid), .busy(busy), .err(err)
    );

    always #5 mclk = ~mclk;

    // Inputs change right after a falling edge; outputs are sampled there too.
    task automatic tick(input int n);
        repeat (n) @(negedge mclk);
    endtask

    task automatic idle_inputs();
        hst_cmd_valid = 0; hst_cmd_adr = '0; hst_cmd_len = 0; hst_cmd_wr_n = 1;
        hst_cmd_be_n = 4'hF; hst_wd_valid = 0; hst_wd = '0; sdc_req_ack = 0;
        sdc_wr_next = 0; sdc_rd_data = '0; sdc_rd_valid = 0;
    endtask

    task automatic apply_reset();
        idle_inputs();
        s_resetn = 0;
        tick(2);
        s_resetn = 1;
        tick(1);
    endtask

    task automatic push_word(input logic [31:0] d);
        hst_wd_valid = 1; hst_wd = d;
        tick(1);
        hst_wd_valid = 0;
    endtask

    task automatic send_cmd(input logic [22:0] adr, input logic [1:0] len,
                            input logic wr_n, input logic [3:0] be_n);
        checks++;
        if (hst_cmd_ready !== 1'b1) begin
            errors++;
            $display("[TB] FAIL cmd_ready before cmd: got %b expected 1", hst_cmd_ready);
        end
        hst_cmd_valid = 1; hst_cmd_adr = adr; hst_cmd_len = len;
        hst_cmd_wr_n = wr_n; hst_cmd_be_n = be_n;
        tick(1);
        hst_cmd_valid = 0;
    endtask

    task automatic test_reset();
        idle_inputs();
        sdc_init_done = 1;
        s_resetn = 0;
        tick(2);
        checks++;
        if ({sdc_req, sdc_req_wr_n, sdc_wr_en_n, busy, err} !== {1'b0, 1'b1, 4'hF, 1'b0, 1'b0}) begin
            errors++;
            $display("[TB] FAIL reset ctl: got req=%b wr_n=%b en_n=%h busy=%b err=%b expected 0 1 f 0 0",
                     sdc_req, sdc_req_wr_n, sdc_wr_en_n, busy, err);
        end
        checks++;
        if ({sdc_req_adr, sdc_req_len, hst_rd_valid, hst_rd_last, hst_rd} !== '0) begin
            errors++;
            $display("[TB] FAIL reset data: got adr=%h len=%0d rv=%b rl=%b rd=%h expected all 0",
                     sdc_req_adr, sdc_req_len, hst_rd_valid, hst_rd_last, hst_rd);
        end
        checks++;
        if (hst_wd_ready !== 1'b1) begin
            errors++;
            $display("[TB] FAIL reset wd_ready: got %b expected 1", hst_wd_ready);
        end
        s_resetn = 1;
        sdc_init_done = 0;
        tick(1);
        checks++;
        if (hst_cmd_ready !== 1'b0) begin
            errors++;
            $display("[TB] FAIL cmd_ready no init: got %b expected 0", hst_cmd_ready);
        end
        sdc_init_done = 1;
        tick(1);
    endtask

    task automatic test_write_basic();
        for (int i = 0; i < 4; i++) push_word(32'(i));
        send_cmd(23'h000200, 2'd0, 1'b0, 4'h0);
        tick(1);
        for (int k = 0; k < 3; k++) begin
            checks++;
            if ({sdc_req, sdc_req_adr, sdc_req_wr_n, sdc_wr_en_n, busy} !== {1'b1, 23'h000200, 1'b0, 4'h0, 1'b1}) begin
                errors++;
                $display("[TB] FAIL wr req hold %0d: got req=%b adr=%h wr_n=%b en_n=%h busy=%b expected 1 000200 0 0 1",
                         k, sdc_req, sdc_req_adr, sdc_req_wr_n, sdc_wr_en_n, busy);
            end
            tick(1);
        end
        sdc_req_ack = 1;
        tick(1);
        sdc_req_ack = 0;
        checks++;
        if (sdc_req !== 1'b0) begin
            errors++;
            $display("[TB] FAIL wr req drop: got %b expected 0", sdc_req);
        end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (sdc_wr_data !== 32'(i)) begin
                errors++;
                $display("[TB] FAIL wr data %0d: got %h expected %h", i, sdc_wr_data, i);
            end
            sdc_wr_next = 1;
            tick(1);
        end
        sdc_wr_next = 0;
        checks++;
        if ({busy, err, dut.fifo_cnt} !== {1'b0, 1'b0, 6'd0}) begin
            errors++;
            $display("[TB] FAIL wr done: got busy=%b err=%b cnt=%0d expected 0 0 0", busy, err, dut.fifo_cnt);
        end
    endtask

    task automatic test_write_wait();
        send_cmd(23'h012345, 2'd3, 1'b0, 4'h5);
        for (int i = 0; i < 20; i++) push_word(32'h100 + 32'(i));
        tick(3);
        checks++;
        if ({sdc_req, busy} !== 2'b01) begin
            errors++;
            $display("[TB] FAIL partial no req: got req=%b busy=%b expected 0 1", sdc_req, busy);
        end
        for (int i = 20; i < 31; i++) push_word(32'h100 + 32'(i));
        tick(1);
        checks++;
        if (sdc_req !== 1'b0) begin
            errors++;
            $display("[TB] FAIL 31 words no req: got %b expected 0", sdc_req);
        end
        push_word(32'h100 + 32'd31);
        tick(1);
        checks++;
        if ({sdc_req, sdc_req_len, sdc_wr_en_n, hst_wd_ready} !== {1'b1, 2'd3, 4'h5, 1'b0}) begin
            errors++;
            $display("[TB] FAIL 32 words req: got req=%b len=%0d en_n=%h wd_ready=%b expected 1 3 5 0",
                     sdc_req, sdc_req_len, sdc_wr_en_n, hst_wd_ready);
        end
        sdc_req_ack = 1;
        for (int i = 0; i < 32; i++) begin
            checks++;
            if (sdc_wr_data !== 32'h100 + 32'(i)) begin
                errors++;
                $display("[TB] FAIL burst32 data %0d: got %h expected %h", i, sdc_wr_data, 32'h100 + 32'(i));
            end
            sdc_wr_next = 1;
            tick(1);
            sdc_req_ack = 0;
        end
        sdc_wr_next = 0;
        checks++;
        if ({busy, err, dut.fifo_cnt} !== {1'b0, 1'b0, 6'd0}) begin
            errors++;
            $display("[TB] FAIL burst32 done: got busy=%b err=%b cnt=%0d expected 0 0 0", busy, err, dut.fifo_cnt);
        end
    endtask

    task automatic test_read();
        send_cmd(23'h600000, 2'd1, 1'b1, 4'hF);
        checks++;
        if ({sdc_req, sdc_req_adr, sdc_req_len, sdc_req_wr_n} !== {1'b1, 23'h600000, 2'd1, 1'b1}) begin
            errors++;
            $display("[TB] FAIL rd req: got req=%b adr=%h len=%0d wr_n=%b expected 1 600000 1 1",
                     sdc_req, sdc_req_adr, sdc_req_len, sdc_req_wr_n);
        end
        sdc_req_ack = 1;
        tick(1);
        sdc_req_ack = 0;
        for (int i = 0; i < 8; i++) begin
            if (i == 3) begin
                tick(1);
                checks++;
                if (hst_rd_valid !== 1'b0) begin
                    errors++;
                    $display("[TB] FAIL rd gap: got valid=%b expected 0", hst_rd_valid);
                end
            end
            sdc_rd_valid = 1; sdc_rd_data = 32'hA0 + 32'(i);
            tick(1);
            sdc_rd_valid = 0;
            checks++;
            if ({hst_rd_valid, hst_rd, hst_rd_last} !== {1'b1, 32'hA0 + 32'(i), i == 7}) begin
                errors++;
                $display("[TB] FAIL rd beat %0d: got v=%b d=%h last=%b expected 1 %h %b",
                         i, hst_rd_valid, hst_rd, hst_rd_last, 32'hA0 + 32'(i), i == 7);
            end
        end
        tick(1);
        checks++;
        if ({hst_rd_valid, hst_rd_last, busy, err} !== 4'b0000) begin
            errors++;
            $display("[TB] FAIL rd done: got v=%b last=%b busy=%b err=%b expected 0 0 0 0",
                     hst_rd_valid, hst_rd_last, busy, err);
        end
    endtask

    task automatic test_fifo_full();
        for (int i = 0; i < 32; i++) push_word(32'h200 + 32'(i));
        checks++;
        if ({hst_wd_ready, dut.fifo_cnt} !== {1'b0, 6'd32}) begin
            errors++;
            $display("[TB] FAIL full: got ready=%b cnt=%0d expected 0 32", hst_wd_ready, dut.fifo_cnt);
        end
        send_cmd(23'h000040, 2'd3, 1'b0, 4'h3);
        tick(1);
        sdc_req_ack = 1;
        tick(1);
        sdc_req_ack = 0;
        sdc_wr_next = 1;
        tick(1);
        checks++;
        if ({hst_wd_ready, dut.fifo_cnt, sdc_wr_data} !== {1'b1, 6'd31, 32'h201}) begin
            errors++;
            $display("[TB] FAIL at 31: got ready=%b cnt=%0d data=%h expected 1 31 201",
                     hst_wd_ready, dut.fifo_cnt, sdc_wr_data);
        end
        hst_wd_valid = 1; hst_wd = 32'h999;
        tick(1);
        hst_wd_valid = 0;
        checks++;
        if (dut.fifo_cnt !== 6'd31) begin
            errors++;
            $display("[TB] FAIL push+pop cnt: got %0d expected 31", dut.fifo_cnt);
        end
        for (int i = 2; i < 32; i++) begin
            checks++;
            if (sdc_wr_data !== 32'h200 + 32'(i)) begin
                errors++;
                $display("[TB] FAIL full burst %0d: got %h expected %h", i, sdc_wr_data, 32'h200 + 32'(i));
            end
            tick(1);
        end
        sdc_wr_next = 0;
        checks++;
        if ({busy, err, dut.fifo_cnt, sdc_wr_data} !== {1'b0, 1'b0, 6'd1, 32'h999}) begin
            errors++;
            $display("[TB] FAIL full done: got busy=%b err=%b cnt=%0d head=%h expected 0 0 1 999",
                     busy, err, dut.fifo_cnt, sdc_wr_data);
        end
    endtask

    task automatic test_err();
        apply_reset();
        sdc_rd_valid = 1; sdc_rd_data = 32'hDEAD;
        tick(1);
        sdc_rd_valid = 0;
        checks++;
        if ({err, hst_rd_valid} !== 2'b10) begin
            errors++;
            $display("[TB] FAIL err rd idle: got err=%b rv=%b expected 1 0", err, hst_rd_valid);
        end
        tick(5);
        checks++;
        if (err !== 1'b1) begin
            errors++;
            $display("[TB] FAIL err sticky: got %b expected 1", err);
        end
        apply_reset();
        checks++;
        if (err !== 1'b0) begin
            errors++;
            $display("[TB] FAIL err clear: got %b expected 0", err);
        end
        sdc_wr_next = 1;
        tick(1);
        sdc_wr_next = 0;
        tick(2);
        checks++;
        if ({err, dut.fifo_cnt} !== {1'b1, 6'd0}) begin
            errors++;
            $display("[TB] FAIL err wr empty: got err=%b cnt=%0d expected 1 0", err, dut.fifo_cnt);
        end
        apply_reset();
        sdc_req_ack = 1;
        tick(1);
        sdc_req_ack = 0;
        checks++;
        if ({err, busy} !== 2'b10) begin
            errors++;
            $display("[TB] FAIL err ack idle: got err=%b busy=%b expected 1 0", err, busy);
        end
    endtask

    task automatic test_reset_mid_read();
        apply_reset();
        send_cmd(23'h1ABCDE, 2'd2, 1'b1, 4'hF);
        sdc_req_ack = 1;
        tick(1);
        sdc_req_ack = 0;
        for (int i = 0; i < 5; i++) begin
            sdc_rd_valid = 1; sdc_rd_data = 32'hC0 + 32'(i);
            tick(1);
        end
        sdc_rd_valid = 0;
        #2 s_resetn = 0;
        #1;
        checks++;
        if ({sdc_req, sdc_req_adr, sdc_req_len, sdc_req_wr_n, sdc_wr_en_n, busy, err}
                !== {1'b0, 23'h0, 2'd0, 1'b1, 4'hF, 1'b0, 1'b0}) begin
            errors++;
            $display("[TB] FAIL midrst ctl: got req=%b adr=%h len=%0d wr_n=%b en_n=%h busy=%b err=%b",
                     sdc_req, sdc_req_adr, sdc_req_len, sdc_req_wr_n, sdc_wr_en_n, busy, err);
        end
        checks++;
        if ({hst_rd_valid, hst_rd_last, hst_rd} !== '0) begin
            errors++;
            $display("[TB] FAIL midrst rd: got v=%b last=%b rd=%h expected 0 0 0", hst_rd_valid, hst_rd_last, hst_rd);
        end
        tick(1);
        s_resetn = 1;
        tick(1);
        send_cmd(23'h000010, 2'd0, 1'b1, 4'hF);
        checks++;
        if ({sdc_req, sdc_req_adr} !== {1'b1, 23'h000010}) begin
            errors++;
            $display("[TB] FAIL post rst req: got req=%b adr=%h expected 1 000010", sdc_req, sdc_req_adr);
        end
        sdc_req_ack = 1;
        tick(1);
        sdc_req_ack = 0;
        for (int i = 0; i < 4; i++) begin
            sdc_rd_valid = 1; sdc_rd_data = 32'hE0 + 32'(i);
            tick(1);
            sdc_rd_valid = 0;
            checks++;
            if ({hst_rd_valid, hst_rd, hst_rd_last} !== {1'b1, 32'hE0 + 32'(i), i == 3}) begin
                errors++;
                $display("[TB] FAIL post rst beat %0d: got v=%b d=%h last=%b", i, hst_rd_valid, hst_rd, hst_rd_last);
            end
        end
        tick(1);
        checks++;
        if ({busy, err} !== 2'b00) begin
            errors++;
            $display("[TB] FAIL post rst done: got busy=%b err=%b expected 0 0", busy, err);
        end
    endtask

    initial begin
        s_resetn = 0;
        sdc_init_done = 0;
        idle_inputs();
        tick(1);
        test_reset();
        test_write_basic();
        test_write_wait();
        test_read();
        test_fifo_full();
        test_err();
        test_reset_mid_read();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
